// File: rtl/n101_tl_width_narrower.sv
// TileLink width narrower: splits inner A beats into narrower outer beats and
// reassembles multi-beat outer D responses into single inner D beats.
module n101_tl_width_narrower #(
   parameter int IN_BYTES  = 4,
   parameter int OUT_BYTES = 1,
   parameter int ADDR_W    = 30,
   parameter int SRC_W     = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_a_valid,
   output logic                   in_a_ready,
   input  logic [2:0]             in_a_opcode,
   input  logic [2:0]             in_a_param,
   input  logic [2:0]             in_a_size,
   input  logic [SRC_W-1:0]       in_a_source,
   input  logic [ADDR_W-1:0]      in_a_address,
   input  logic [IN_BYTES-1:0]    in_a_mask,
   input  logic [8*IN_BYTES-1:0]  in_a_data,
   output logic                   out_a_valid,
   input  logic                   out_a_ready,
   output logic [2:0]             out_a_opcode,
   output logic [2:0]             out_a_param,
   output logic [2:0]             out_a_size,
   output logic [SRC_W-1:0]       out_a_source,
   output logic [ADDR_W-1:0]      out_a_address,
   output logic [OUT_BYTES-1:0]   out_a_mask,
   output logic [8*OUT_BYTES-1:0] out_a_data,
   input  logic                   out_d_valid,
   output logic                   out_d_ready,
   input  logic [2:0]             out_d_opcode,
   input  logic [1:0]             out_d_param,
   input  logic [2:0]             out_d_size,
   input  logic [SRC_W-1:0]       out_d_source,
   input  logic                   out_d_sink,
   input  logic [8*OUT_BYTES-1:0] out_d_data,
   input  logic                   out_d_error,
   output logic                   in_d_valid,
   input  logic                   in_d_ready,
   output logic [2:0]             in_d_opcode,
   output logic [1:0]             in_d_param,
   output logic [2:0]             in_d_size,
   output logic [SRC_W-1:0]       in_d_source,
   output logic                   in_d_sink,
   output logic [8*IN_BYTES-1:0]  in_d_data,
   output logic                   in_d_error
);

   localparam int R      = IN_BYTES / OUT_BYTES;
   localparam int CNT_W  = (R > 1) ? $clog2(R) : 1;
   localparam int CW1    = CNT_W + 1;
   localparam int IN_LG  = $clog2(IN_BYTES);
   localparam int OUT_LG = $clog2(OUT_BYTES);
   localparam int OW     = 8 * OUT_BYTES;
   localparam int IW     = 8 * IN_BYTES;

   // Number of outer beats needed to carry a transfer of 2^size bytes.
   function automatic logic [CW1-1:0] beats_of(input logic [2:0] size);
      if (int'(size) <= OUT_LG) return CW1'(1);
      return CW1'(1) << (int'(size) - OUT_LG);
   endfunction

   logic [CNT_W-1:0] a_cnt;
   logic [CNT_W-1:0] d_cnt;
   logic [CW1-1:0]   a_beats;
   logic [CW1-1:0]   d_span;
   logic             last_a;
   logic             last_d;
   logic             a_fire;
   logic             d_fire;
   logic             err_acc;

   assign a_beats       = beats_of(in_a_size);
   assign last_a        = ({1'b0, a_cnt} == (a_beats - CW1'(1)));
   assign out_a_valid   = in_a_valid;
   assign in_a_ready    = out_a_ready & last_a;
   assign a_fire        = in_a_valid & out_a_ready;
   assign out_a_opcode  = in_a_opcode;
   assign out_a_param   = in_a_param;
   assign out_a_size    = in_a_size;
   assign out_a_source  = in_a_source;
   assign out_a_address = in_a_address;

   assign d_span      = (out_d_opcode == 3'd1) ? beats_of(out_d_size) : CW1'(1);
   assign last_d      = ({1'b0, d_cnt} == (d_span - CW1'(1)));
   assign out_d_ready = in_d_ready | ~last_d;
   assign in_d_valid  = out_d_valid & last_d;
   assign d_fire      = out_d_valid & out_d_ready;
   assign in_d_opcode = out_d_opcode;
   assign in_d_param  = out_d_param;
   assign in_d_size   = out_d_size;
   assign in_d_source = out_d_source;
   assign in_d_sink   = out_d_sink;
   assign in_d_error  = out_d_error | err_acc;

   always_ff @(posedge clock) begin
      if (reset) begin
         a_cnt <= '0;
      end else if (a_fire) begin
         a_cnt <= last_a ? '0 : a_cnt + CNT_W'(1);
      end
   end

   // Errors on intermediate beats are held until the merged beat leaves.
   always_ff @(posedge clock) begin
      if (reset) begin
         d_cnt   <= '0;
         err_acc <= 1'b0;
      end else if (d_fire) begin
         if (last_d) begin
            d_cnt   <= '0;
            err_acc <= 1'b0;
         end else begin
            d_cnt   <= d_cnt + CNT_W'(1);
            err_acc <= err_acc | out_d_error;
         end
      end
   end

   generate
      if (R == 1) begin : g_same_width
         assign out_a_data = in_a_data;
         assign out_a_mask = in_a_mask;
         assign in_d_data  = out_d_data;
      end else begin : g_narrow
         logic [CNT_W-1:0] addr_lane;
         logic [CNT_W-1:0] align_mask;
         logic [CNT_W-1:0] lane;
         logic [IW-OW-1:0] dbuf;
         logic [IW-1:0]    full;

         assign addr_lane  = in_a_address[IN_LG-1:OUT_LG];
         assign align_mask = CNT_W'(a_beats - CW1'(1));
         assign lane       = (addr_lane & ~align_mask) + a_cnt;
         assign out_a_data = in_a_data[lane*OW +: OW];
         assign out_a_mask = in_a_mask[lane*OUT_BYTES +: OUT_BYTES];
         assign full       = {out_d_data, dbuf};

         always_ff @(posedge clock) begin
            if (reset) begin
               dbuf <= '0;
            end else if (d_fire && !last_d) begin
               dbuf <= full[IW-1:OW];
            end
         end

         // The assembled bytes sit at the top of full; small responses repeat across the word.
         always_comb begin
            int nbytes;
            nbytes    = int'(d_span) * OUT_BYTES;
            in_d_data = '0;
            for (int i = 0; i < IN_BYTES; i++) begin
               in_d_data[8*i +: 8] = full[8*(IN_BYTES - nbytes + (i % nbytes)) +: 8];
            end
         end
      end
   endgenerate

endmodule
